// File: rtl/mips_reg_file.sv
// ============================================================================
// mips_reg_file : 32-entry MIPS general-purpose register file, 2R/1W, $0 = 0.
// Optional write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [ADDR_W-1:0] in_rd_addr_a,
  input  logic [ADDR_W-1:0] in_rd_addr_b,
  output logic [DATA_W-1:0] out_rd_data_a,
  output logic [DATA_W-1:0] out_rd_data_b,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0] in_wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 has no storage; it only exists as a constant in the read view.
  logic [DATA_W-1:0] regs_q  [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d  [1:DEPTH-1];
  logic [DATA_W-1:0] rd_view [0:DEPTH-1];

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (in_wr_en && (in_wr_addr == ADDR_W'(i))) begin
        regs_d[i] = in_wr_data;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_view
      assign rd_view[gi] = regs_q[gi];
    end
  endgenerate

`ifdef REG_FILE_BYPASS_EN
  logic wr_live;
  logic byp_a;
  logic byp_b;

  // Forwarding is suppressed during reset so both ports still read zero.
  assign wr_live = in_rst_n && in_wr_en && (in_wr_addr != '0);
  assign byp_a   = wr_live && (in_wr_addr == in_rd_addr_a);
  assign byp_b   = wr_live && (in_wr_addr == in_rd_addr_b);

  always_comb begin
    out_rd_data_a = rd_view[in_rd_addr_a];
    out_rd_data_b = rd_view[in_rd_addr_b];
    if (byp_a) out_rd_data_a = in_wr_data;
    if (byp_b) out_rd_data_b = in_wr_data;
  end
`else
  always_comb begin
    out_rd_data_a = rd_view[in_rd_addr_a];
    out_rd_data_b = rd_view[in_rd_addr_b];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_reg_file.sv
// ============================================================================
// tb_mips_reg_file : directed table, corner sequences and random traffic
// against a simple array model of the register file.
// ============================================================================
`default_nettype none

module tb_mips_reg_file;

  logic        in_clk;
  logic        in_rst_n;
  logic [4:0]  in_rd_addr_a;
  logic [4:0]  in_rd_addr_b;
  logic [31:0] out_rd_data_a;
  logic [31:0] out_rd_data_b;
  logic        in_wr_en;
  logic [4:0]  in_wr_addr;
  logic [31:0] in_wr_data;

  mips_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_rd_addr_a  (in_rd_addr_a),
    .in_rd_addr_b  (in_rd_addr_b),
    .out_rd_data_a (out_rd_data_a),
    .out_rd_data_b (out_rd_data_b),
    .in_wr_en      (in_wr_en),
    .in_wr_addr    (in_wr_addr),
    .in_wr_data    (in_wr_data)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] mem [0:31];

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if ($isunknown(act) || act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (BYP && in_rst_n && in_wr_en && in_wr_addr != 5'd0 && in_wr_addr == addr)
      return in_wr_data;
    return mem[addr];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    in_wr_en     = we;
    in_wr_addr   = wa;
    in_wr_data   = wd;
    in_rd_addr_a = ra;
    in_rd_addr_b = rb;
  endtask

  // Advance one rising edge and commit the architectural effect to the model.
  task automatic tick();
    @(posedge in_clk);
    if (in_rst_n && in_wr_en && in_wr_addr != 5'd0) mem[in_wr_addr] = in_wr_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic sweep(input string name);
    in_wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      in_rd_addr_a = 5'(i);
      in_rd_addr_b = 5'(31 - i);
      #1;
      check({name, "_a"}, out_rd_data_a, model_read(in_rd_addr_a));
      check({name, "_b"}, out_rd_data_b, model_read(in_rd_addr_b));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  32'hA,          5'd0,  5'd0,  32'h0, 32'h0};
    vecs[1]  = '{1'b1, 5'd2,  32'hB,          5'd1,  5'd3,  32'hA, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,          5'd1,  5'd2,  32'hA, 32'hB};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,          5'd2,  5'd1,  32'hB, 32'hA};
    vecs[4]  = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd0,  32'h0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,          5'd0,  5'd0,  32'h0, 32'h0};
    vecs[6]  = '{1'b1, 5'd5,  32'h4,          5'd1,  5'd1,  32'hA, 32'hA};
    vecs[7]  = '{1'b0, 5'd5,  32'h3,          5'd5,  5'd5,  32'h4, 32'h4};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,          5'd5,  5'd2,  32'h4, 32'hB};
    vecs[9]  = '{1'b1, 5'd7,  32'h1,          5'd2,  5'd2,  32'hB, 32'hB};
    vecs[10] = '{1'b1, 5'd7,  32'h2,          5'd7,  5'd0,  (BYP ? 32'h2 : 32'h1), 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,          5'd7,  5'd7,  32'h2, 32'h2};
    vecs[12] = '{1'b1, 5'd31, 32'hFFFFFFFF,   5'd30, 5'd31, 32'h0, (BYP ? 32'hFFFFFFFF : 32'h0)};
    vecs[13] = '{1'b0, 5'd0,  32'h0,          5'd31, 5'd1,  32'hFFFFFFFF, 32'hA};

    clear_model();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd17);
    in_rst_n = 1'b0;
    #12;
    check("rst_hold_a", out_rd_data_a, 32'h0);
    check("rst_hold_b", out_rd_data_b, 32'h0);
    #10 in_rst_n = 1'b1;
    tick();
    sweep("post_reset");

    // Directed table; each vector checked before its edge.
    tick();
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb);
      #2;
      check($sformatf("vec%0d_a", v), out_rd_data_a, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), out_rd_data_b, vecs[v].exp_b);
      tick();
    end
    sweep("after_table");

    // $0 with a pending write to $0 reads zero in both builds.
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    #2;
    check("r0_pend_a", out_rd_data_a, 32'h0);
    check("r0_pend_b", out_rd_data_b, 32'h0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom % 4) != 0, wa, $urandom,
            (($urandom % 4) == 0) ? wa : 5'($urandom_range(0, 31)),
            (($urandom % 4) == 0) ? wa : 5'($urandom_range(0, 31)));
      #2;
      check("rnd_pre_a", out_rd_data_a, model_read(in_rd_addr_a));
      check("rnd_pre_b", out_rd_data_b, model_read(in_rd_addr_b));
      tick();
      check("rnd_post_a", out_rd_data_a, model_read(in_rd_addr_a));
      check("rnd_post_b", out_rd_data_b, model_read(in_rd_addr_b));
    end

    // Mid-run asynchronous reset clears outputs without a clock edge.
    drive(1'b1, 5'd1, 32'h11111111, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd31, 32'h31313131, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    check("pre_async_a", out_rd_data_a, 32'h11111111);
    check("pre_async_b", out_rd_data_b, 32'h31313131);
    in_rst_n = 1'b0;
    #1;
    check("async_rst_a", out_rd_data_a, 32'h0);
    check("async_rst_b", out_rd_data_b, 32'h0);
    clear_model();
    sweep("in_reset");
    in_rst_n = 1'b1;
    tick();

    // Write in flight when reset asserts: reset wins.
    drive(1'b1, 5'd9, 32'h00001234, 5'd9, 5'd9);
    #2;
    in_rst_n = 1'b0;
    #1;
    check("rst_wr_during_a", out_rd_data_a, 32'h0);
    tick();
    clear_model();
    in_rst_n = 1'b1;
    drive(1'b0, 5'd9, 32'h00001234, 5'd9, 5'd9);
    #1;
    check("rst_wr_lost_a", out_rd_data_a, 32'h0);
    check("rst_wr_lost_b", out_rd_data_b, 32'h0);
    drive(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd0);
    #1;
    check("first_wr_pre", out_rd_data_a, BYP ? 32'h55 : 32'h0);
    tick();
    check("first_wr_post", out_rd_data_a, 32'h55);
    sweep("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
